// File: rtl/operand_loader_if.sv
// Bus bundle for operand_loader: byte stream in, compute-block handshakes, result port out.
// slave is the loader's view; master is the view of whatever surrounds it.
interface operand_loader_if;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [1:0]       cfg_mode;

  // element 0 is a11 / b11, row-major
  logic [15:0][7:0] a;
  logic [8:0][7:0]  b;

  logic             active_store;
  logic             active_single;
  logic             active_sa3;
  logic             active_sa2;
  logic             done_store;
  logic             done_single;
  logic             done_sa3;
  logic             done_sa2;
  logic [7:0]       c11;
  logic [7:0]       c12;
  logic [7:0]       c21;
  logic [7:0]       c22;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             busy;
  logic             err;

  modport slave (
    input  in_valid, in_data, cfg_mode,
    input  done_store, done_single, done_sa3, done_sa2,
    input  c11, c12, c21, c22,
    input  res_ready,
    output in_ready, a, b,
    output active_store, active_single, active_sa3, active_sa2,
    output res_valid, res_data, busy, err
  );

  modport master (
    output in_valid, in_data, cfg_mode,
    output done_store, done_single, done_sa3, done_sa2,
    output c11, c12, c21, c22,
    output res_ready,
    input  in_ready, a, b,
    input  active_store, active_single, active_sa3, active_sa2,
    input  res_valid, res_data, busy, err
  );
endinterface

// File: rtl/operand_loader.sv
// Loads a 25-byte operand frame, sequences the compute-block handshakes and
// returns the 2x2 result as one 32-bit word.
//
// state    | meaning
// S_LOAD   | accepting operand bytes, in_ready high
// S_STORE  | active_store held until done_store or timeout
// S_RUN    | mode-selected active_* held until its done or timeout
// S_RESULT | res_valid held with stable res_data until res_ready
module operand_loader #(
  parameter int TIMEOUT = 63,
  parameter int CNT_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_STORE  = 2'd1,
    S_RUN    = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [1:0]       M_SINGLE    = 2'b00;
  localparam logic [1:0]       M_SA3       = 2'b01;
  localparam logic [1:0]       M_SA2       = 2'b10;
  localparam logic [1:0]       M_LOAD_ONLY = 2'b11;
  localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [4:0]       r_byte_cnt;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_tmo;
  logic [15:0][7:0] r_a;
  logic [8:0][7:0]  r_b;
  logic             r_act_store;
  logic             r_act_single;
  logic             r_act_sa3;
  logic             r_act_sa2;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic             r_err;

  logic             w_accept;
  logic             w_run_done;
  logic             w_tmo_tc;

  assign w_accept = bus.in_valid && (r_state == S_LOAD);
  // Timer counts down from TIMEOUT-1, so terminal count lands on the TIMEOUT-th cycle
  assign w_tmo_tc = (r_tmo == '0);

  always_comb begin
    w_run_done = 1'b0;
    case (r_mode)
      M_SINGLE: w_run_done = bus.done_single;
      M_SA3:    w_run_done = bus.done_sa3;
      M_SA2:    w_run_done = bus.done_sa2;
      default:  w_run_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_byte_cnt   <= '0;
      r_mode       <= M_SINGLE;
      r_tmo        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_act_store  <= 1'b0;
      r_act_single <= 1'b0;
      r_act_sa3    <= 1'b0;
      r_act_sa2    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            // indices 16..24 share their low nibble with b offsets 0..8
            if (r_byte_cnt < 5'd16) r_a[r_byte_cnt[3:0]] <= bus.in_data;
            else                    r_b[r_byte_cnt[3:0]] <= bus.in_data;
            if (r_byte_cnt == 5'd0) r_mode <= bus.cfg_mode;
            if (r_byte_cnt == 5'd24) begin
              r_byte_cnt  <= '0;
              r_state     <= S_STORE;
              r_act_store <= 1'b1;
              r_tmo       <= TMO_LOAD;
            end else begin
              r_byte_cnt <= r_byte_cnt + 5'd1;
            end
          end
        end

        S_STORE: begin
          if (bus.done_store) begin
            r_act_store <= 1'b0;
            if (r_mode == M_LOAD_ONLY) begin
              r_state <= S_LOAD;
            end else begin
              r_state      <= S_RUN;
              r_tmo        <= TMO_LOAD;
              r_act_single <= (r_mode == M_SINGLE);
              r_act_sa3    <= (r_mode == M_SA3);
              r_act_sa2    <= (r_mode == M_SA2);
            end
          end else if (w_tmo_tc) begin
            r_err       <= 1'b1;
            r_act_store <= 1'b0;
            r_byte_cnt  <= '0;
            r_state     <= S_LOAD;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end

        S_RUN: begin
          if (w_run_done) begin
            r_res_data   <= {bus.c11, bus.c12, bus.c21, bus.c22};
            r_res_valid  <= 1'b1;
            r_act_single <= 1'b0;
            r_act_sa3    <= 1'b0;
            r_act_sa2    <= 1'b0;
            r_state      <= S_RESULT;
          end else if (w_tmo_tc) begin
            r_err        <= 1'b1;
            r_act_single <= 1'b0;
            r_act_sa3    <= 1'b0;
            r_act_sa2    <= 1'b0;
            r_byte_cnt   <= '0;
            r_state      <= S_LOAD;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end

        S_RESULT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_LOAD;
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready      = (r_state == S_LOAD);
  assign bus.busy          = (r_state != S_LOAD);
  assign bus.a             = r_a;
  assign bus.b             = r_b;
  assign bus.active_store  = r_act_store;
  assign bus.active_single = r_act_single;
  assign bus.active_sa3    = r_act_sa3;
  assign bus.active_sa2    = r_act_sa2;
  assign bus.res_valid     = r_res_valid;
  assign bus.res_data      = r_res_data;
  assign bus.err           = r_err;

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for `computation_module`. It accepts a 25-byte operand frame over a valid/ready byte stream and registers it as the 4x4 activation matrix `a11..a44` and the 3x3 kernel `b11..b33`. It then sequences the `active_store` / `active_single` / `active_sa3` / `active_sa2` handshakes with the compute block. It captures the resulting 2x2 output `c11..c22` into a single 32-bit word and presents it on a valid/ready result port.

## Interface
Parameters:
- `TIMEOUT`, 63: maximum cycles to wait for any `done_*` before aborting.
- `CNT_W`, 6: width of the timeout counter; must hold `TIMEOUT`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte stream valid.
- `in_ready`  out  1  byte stream ready.
- `in_data`  in  8  operand byte.
- `cfg_mode`  in  2  compute mode, sampled on acceptance of byte 0:
  - 00: single
  - 01: sa3
  - 10: sa2
  - 11: load-only
- `a11..a44`  out  8 each  activation registers, row-major.
- `b11..b33`  out  8 each  kernel registers, row-major.
- `active_store`, `active_single`, `active_sa3`, `active_sa2`  out  1 each  level-held requests to the compute block.
- `done_store`, `done_single`, `done_sa3`, `done_sa2`  in  1 each  completion flags from the compute block.
- `c11`, `c12`, `c21`, `c22`  in  8 each  compute results.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result ready.
- `res_data`  out  32  result word, {c11,c12,c21,c22}; `c11` in bits [31:24].
- `busy`  out  1  high in any state other than LOAD.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
States:
- **LOAD**
  - `in_ready`=1.
  - Each accepted byte (`in_valid`&`in_ready`) is written at index `byte_cnt`, and `byte_cnt` increments.
  - Indices 0–15 map to `a11..a44`; indices 16–24 map to `b11..b33`.
  - On acceptance of index 24: `byte_cnt` returns to 0 and the next state is STORE.
- **STORE**
  - `active_store`=1.
  - When `done_store` is sampled 1: go to RUN, or to LOAD if the latched mode is 11.
- **RUN**
  - Exactly one `active_*` is high, selected by the latched mode.
  - When the matching `done_*` is sampled 1: load `res_data` from `c11..c22` on that edge and go to RESULT.
  - Non-matching `done_*` inputs are ignored.
- **RESULT**
  - `res_valid`=1 and `res_data` is held stable.
  - When `res_valid`&`res_ready`: go to LOAD.

Timeout:
- The timeout counter clears on entry to STORE and RUN and increments every cycle spent in those states.
- When it reaches `TIMEOUT` with no qualifying done: set `err`, deassert all `active_*`, and go to LOAD with `byte_cnt`=0.
- If done and timeout occur in the same cycle, done wins and `err` is not set.

Operand registers:
- They change only on byte acceptance.
- They are held through STORE, RUN and RESULT, so the compute block always sees stable operands.

`cfg_mode` changes after byte 0 have no effect on the current frame.

## Timing
- All outputs are registered, except `in_ready` and `busy`, which are decoded directly from the state register.
- Reset values:
  - state LOAD, so `in_ready`=1 and `busy`=0.
  - `byte_cnt`=0.
  - all `a`/`b` registers 0.
  - all `active_*` 0.
  - `res_valid`=0, `res_data`=0, `err`=0.
- `active_store` rises in the cycle after byte 24 is accepted.
- Each `active_*` falls in the cycle after its done is sampled high. The following `active_*` rises in that same cycle, so there is no idle gap.
- `res_valid` rises in the cycle after the mode's done is sampled.
- After the result handshake, `in_ready` is 1 on the following cycle.
- Minimum frame-to-result latency is 25 accept cycles + 1 (STORE) + 1 (RUN) + 1 = 28 cycles.
- Reset asserted mid-operation drops all `active_*` and `res_valid` immediately (asynchronously) and discards any partial frame.
- `in_valid` while not in LOAD has no effect; no byte is consumed.

## Test plan
- **Reference frame, mode 00.**
  - Stimulus: reset, then stream a rows {1,2,3,4}×4 and b rows {1,1,1},{2,2,2},{3,3,3} with `in_valid` held 1.
  - Expected: `a11`=1, `a44`=4, `b33`=3; `active_store` high from cycle 26 until `done_store`; then `active_single` until `done_single`; `res_data` = {c11,c12,c21,c22} captured at done.
- **Bubbled input, mode 10.**
  - Stimulus: `in_valid` toggled every other cycle.
  - Expected: exactly 25 bytes accepted; `active_sa2` is the only run request; `active_single` and `active_sa3` stay 0.
- **Load-only, mode 11.**
  - Stimulus: full frame, then `done_store` pulsed.
  - Expected: state returns to LOAD, `res_valid` never rises, `in_ready`=1 one cycle after `done_store`.
- **Result backpressure.**
  - Stimulus: `res_ready`=0 for 10 cycles, then 1.
  - Expected: `res_data` stable for all 10 cycles; `in_ready`=0 until the handshake, then 1 on the next cycle.
- **Timeout.**
  - Stimulus: `TIMEOUT`=63, `done_store` never asserted.
  - Expected: `active_store` high for 63 cycles, then 0; `err`=1 and stays 1; a new frame is accepted. Done arriving in the 63rd cycle: `err` stays 0.
- **Reset mid-RUN.**
  - Stimulus: `rst`=0 during `active_sa3`.
  - Expected: `active_sa3`=0 at once; all `a`/`b`=0; `byte_cnt`=0; `busy`=0.
